// File: rtl/rmw_pkg.sv
// rmw_pkg: shared op and FSM state encodings for the read-modify-write memory pipe
package rmw_pkg;
    typedef enum logic [1:0] {
        OP_READ = 2'd0,
        OP_INC  = 2'd1,
        OP_ADD  = 2'd2,
        OP_COPY = 2'd3
    } op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/rmw_alu.sv
// rmw_alu: combinational next-word computation for one read-modify-write request
module rmw_alu
    import rmw_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] old_i,
    input  logic [WIDTH-1:0] addend_i,
    input  logic [WIDTH-1:0] copy_src_i,
    output logic [WIDTH-1:0] new_o,
    output logic             write_en_o
);
    // select the replacement word; READ leaves the word untouched and never writes
    always_comb begin
        new_o      = op_i == OP_INC  ? old_i + WIDTH'(1) :
                     op_i == OP_ADD  ? old_i + addend_i :
                     op_i == OP_COPY ? copy_src_i : old_i;
        write_en_o = op_i != OP_READ;
    end
endmodule

// File: rtl/rmw_mem_pipe.sv
// rmw_mem_pipe: two-stage read-modify-write memory with zeroing sweep after reset
module rmw_mem_pipe
    import rmw_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int OFFSET = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_in_valid,
    output logic                     io_in_ready,
    input  logic [1:0]               io_in_op,
    input  logic [$clog2(DEPTH)-1:0] io_in_addr,
    input  logic [WIDTH-1:0]         io_in_data,
    output logic                     io_out_valid,
    input  logic                     io_out_ready,
    output logic [WIDTH-1:0]         io_out_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] OFF = AW'(OFFSET % DEPTH);

    state_e            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              s1_valid_q, s1_valid_d;
    op_e               s1_op_q, s1_op_d;
    logic [AW-1:0]     s1_addr_q, s1_addr_d;
    logic [WIDTH-1:0]  s1_data_q, s1_data_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              s1_advance, accept, write_en;
    logic [WIDTH-1:0]  old_word, copy_src, new_word;

    // stage 1 reads the target and the COPY source combinationally; address sum wraps mod DEPTH
    assign old_word   = mem_q[s1_addr_q];
    assign copy_src   = mem_q[s1_addr_q + OFF];
    assign s1_advance = s1_valid_q && (!out_valid_q || io_out_ready);
    assign accept     = io_in_valid && io_in_ready;

    rmw_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i       (s1_op_q),
        .old_i      (old_word),
        .addend_i   (s1_data_q),
        .copy_src_i (copy_src),
        .new_o      (new_word),
        .write_en_o (write_en)
    );

    // FSM: sweep one word per cycle in INIT, then accept requests in RUN
    always_comb begin
        state_d     = state_q == ST_INIT && ptr_q == AW'(DEPTH - 1) ? ST_RUN : state_q;
        ptr_d       = state_q == ST_INIT ? ptr_q + AW'(1) : ptr_q;
        io_in_ready = state_q == ST_RUN && (!s1_valid_q || s1_advance);
    end

    // pipeline next state: stage 1 captures on accept, output loads the old word on advance
    always_comb begin
        s1_valid_d  = accept || (s1_valid_q && !s1_advance);
        s1_op_d     = accept ? op_e'(io_in_op) : s1_op_q;
        s1_addr_d   = accept ? io_in_addr : s1_addr_q;
        s1_data_d   = accept ? io_in_data : s1_data_q;
        out_valid_d = s1_advance || (out_valid_q && !io_out_ready);
        out_data_d  = s1_advance ? old_word : out_data_q;
    end

    // state and pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_READ;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_addr_q   <= s1_addr_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // memory writes: zeroing sweep in INIT, otherwise one write per advancing request
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_INIT)
                mem_q[ptr_q] <= '0;
            else if (s1_advance && write_en)
                mem_q[s1_addr_q] <= new_word;
        end
    end

    assign io_out_valid = out_valid_q;
    assign io_out_data  = out_data_q;
endmodule
